// File: rtl/asym_pack_fifo_pkg.sv
// Shared width helpers, default-configuration constants and the fault-kind enum
// for the narrow-to-wide packing FIFO.
package asym_pack_fifo_pkg;

  function automatic int clog2_f(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Bits needed to hold 0..maxValue, never less than one.
  function automatic int width_for(input int maxValue);
    int w;
    w = clog2_f(maxValue + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 24;
  localparam int DEF_DEPTH = 8;

  localparam int K      = DEF_OUT_W / DEF_IN_W;
  localparam int PCNT_W = width_for(K - 1);
  localparam int ADDR_W = width_for(DEF_DEPTH - 1);
  localparam int CNT_W  = width_for(DEF_DEPTH);

  typedef enum logic [1:0] {
    NONE,
    OVERFLOW,
    UNDERFLOW,
    FLUSH_FULL
  } fault_e;

endpackage

// File: rtl/asym_pack_fifo_inbuf.sv
// Sub-word packer: collects narrow pushes into one wide word, zero-padding
// unfilled slots when a partial word is flushed.
module asym_pack_fifo_inbuf
  import asym_pack_fifo_pkg::*;
#(
  parameter int InW       = 8,
  parameter int OutW      = 24,
  parameter int ByteOrder = 0,
  localparam int NumSlots = OutW / InW,
  localparam int PcntW    = width_for(NumSlots - 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             flush_i,
  input  logic             accept_i,
  input  logic [InW-1:0]   data_in_i,
  output logic [PcntW-1:0] pcnt_o,
  output logic [PcntW-1:0] pcnt_next_o,
  output logic             word_valid_o,
  output logic [OutW-1:0]  word_o
);

  logic [PcntW-1:0] pcntQ, pcntD;
  logic [InW-1:0]   slotQ [NumSlots-1];
  logic             lastSlot;

  assign lastSlot     = (pcntQ == PcntW'(NumSlots - 1));
  assign word_valid_o = (push_i && lastSlot) || (flush_i && (push_i || pcntQ != '0));
  assign pcnt_o       = pcntQ;
  assign pcnt_next_o  = pcntD;

  // A rejected word write leaves the packer untouched, push included.
  always_comb begin
    pcntD = pcntQ;
    if (word_valid_o) begin
      if (accept_i) pcntD = '0;
    end else if (push_i) begin
      pcntD = pcntQ + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pcntQ <= '0;
    else       pcntQ <= pcntD;
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !word_valid_o) slotQ[pcntQ] <= data_in_i;
  end

  for (genvar g = 0; g < NumSlots; g++) begin : gSlot
    logic [InW-1:0] slotVal;
    if (g < NumSlots - 1) begin : gStored
      assign slotVal = (PcntW'(g) < pcntQ) ? slotQ[g] :
                       (push_i && PcntW'(g) == pcntQ) ? data_in_i : '0;
    end else begin : gLast
      assign slotVal = (push_i && lastSlot) ? data_in_i : '0;
    end
    if (ByteOrder == 0) begin : gMsbFirst
      assign word_o[OutW-1-g*InW -: InW] = slotVal;
    end else begin : gLsbFirst
      assign word_o[g*InW +: InW] = slotVal;
    end
  end

endmodule

// File: rtl/asym_pack_fifo_s1.sv
// Single-clock narrow-to-wide packing FIFO with show-ahead output and registered flags.
// Build macro ASYM_PACK_FIFO_STICKY_ERR_EN makes error latch until reset.
module asym_pack_fifo_s1
  import asym_pack_fifo_pkg::*;
#(
  parameter int data_in_width  = 8,
  parameter int data_out_width = 24,
  parameter int depth          = 8,
  parameter int ae_level       = 2,
  parameter int af_level       = 2,
  parameter int byte_order     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_req_n,
  input  logic                      flush_n,
  input  logic                      pop_req_n,
  input  logic [data_in_width-1:0]  data_in,
  output logic                      empty,
  output logic                      almost_empty,
  output logic                      half_full,
  output logic                      almost_full,
  output logic                      ram_full,
  output logic                      full,
  output logic                      part_wd,
  output logic                      error,
  output logic [data_out_width-1:0] data_out
);

  localparam int NumSlots = data_out_width / data_in_width;
  localparam int PcntW    = width_for(NumSlots - 1);
  localparam int AddrW    = width_for(depth - 1);
  localparam int CntW     = width_for(depth);

  logic                      pushReq, flushReq, popReq;
  logic                      popOk, wrAllowed, wrEn, wordValid;
  logic [PcntW-1:0]          pcnt, pcntNext;
  logic [data_out_width-1:0] word;
  logic [CntW-1:0]           countQ, countD;
  logic [AddrW-1:0]          wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [data_out_width-1:0] ramQ [depth];
  fault_e                    fault;
  logic emptyQ, emptyD, almostEmptyQ, almostEmptyD, halfFullQ, halfFullD;
  logic almostFullQ, almostFullD, ramFullQ, ramFullD, fullQ, fullD;
  logic partWdQ, partWdD, errorQ, errorD;

  assign pushReq  = !push_req_n;
  assign flushReq = !flush_n;
  assign popReq   = !pop_req_n;

  function automatic logic [AddrW-1:0] nextAddr(input logic [AddrW-1:0] p);
    return (p == AddrW'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  asym_pack_fifo_inbuf #(
    .InW       (data_in_width),
    .OutW      (data_out_width),
    .ByteOrder (byte_order)
  ) uInbuf (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (pushReq),
    .flush_i      (flushReq),
    .accept_i     (wrAllowed),
    .data_in_i    (data_in),
    .pcnt_o       (pcnt),
    .pcnt_next_o  (pcntNext),
    .word_valid_o (wordValid),
    .word_o       (word)
  );

  // A full RAM still takes a word when a valid pop frees a slot on the same edge.
  always_comb begin
    popOk     = popReq && (countQ != '0);
    wrAllowed = (countQ != CntW'(depth)) || popOk;
    wrEn      = wordValid && wrAllowed;
    fault     = NONE;
    if (wordValid && !wrAllowed) begin
      fault = (pushReq && pcnt == PcntW'(NumSlots - 1)) ? OVERFLOW : FLUSH_FULL;
    end else if (popReq && countQ == '0) begin
      fault = UNDERFLOW;
    end
    countD = countQ;
    if (wrEn && !popOk)      countD = countQ + 1'b1;
    else if (popOk && !wrEn) countD = countQ - 1'b1;
    wrPtrD = wrEn  ? nextAddr(wrPtrQ) : wrPtrQ;
    rdPtrD = popOk ? nextAddr(rdPtrQ) : rdPtrQ;
  end

  always_comb begin
    emptyD       = (countD == '0);
    almostEmptyD = (32'(countD) <= ae_level);
    halfFullD    = (32'(countD) >= (depth + 1) / 2);
    almostFullD  = (32'(countD) + af_level >= depth);
    ramFullD     = (countD == CntW'(depth));
    fullD        = ramFullD && (pcntNext == PcntW'(NumSlots - 1));
    partWdD      = (pcntNext != '0);
`ifdef ASYM_PACK_FIFO_STICKY_ERR_EN
    errorD       = errorQ || (fault != NONE);
`else
    errorD       = (fault != NONE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ       <= '0;
      wrPtrQ       <= '0;
      rdPtrQ       <= '0;
      emptyQ       <= 1'b1;
      almostEmptyQ <= 1'b1;
      halfFullQ    <= 1'b0;
      almostFullQ  <= 1'b0;
      ramFullQ     <= 1'b0;
      fullQ        <= 1'b0;
      partWdQ      <= 1'b0;
      errorQ       <= 1'b0;
    end else begin
      countQ       <= countD;
      wrPtrQ       <= wrPtrD;
      rdPtrQ       <= rdPtrD;
      emptyQ       <= emptyD;
      almostEmptyQ <= almostEmptyD;
      halfFullQ    <= halfFullD;
      almostFullQ  <= almostFullD;
      ramFullQ     <= ramFullD;
      fullQ        <= fullD;
      partWdQ      <= partWdD;
      errorQ       <= errorD;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) ramQ[wrPtrQ] <= word;
  end

  assign empty        = emptyQ;
  assign almost_empty = almostEmptyQ;
  assign half_full    = halfFullQ;
  assign almost_full  = almostFullQ;
  assign ram_full     = ramFullQ;
  assign full         = fullQ;
  assign part_wd      = partWdQ;
  assign error        = errorQ;
  assign data_out     = emptyQ ? '0 : ramQ[rdPtrQ];

endmodule

// File: tb/tb_asym_pack_fifo_s1.sv
// Randomized bench for asym_pack_fifo_s1: two instances (MSB-first and LSB-first)
// share stimulus and are checked against a queue-based model of the packing FIFO.
module tb_asym_pack_fifo_s1;

  localparam int K     = 3;
  localparam int DEPTH = 8;

  logic        clk, rst, push_req_n, flush_n, pop_req_n;
  logic [7:0]  data_in;
  logic        emptyS[2], almostEmptyS[2], halfFullS[2], almostFullS[2];
  logic        ramFullS[2], fullS[2], partWdS[2], errorS[2];
  logic [23:0] dataOutS[2];

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]  pend[$];
  logic [7:0]  stage[$];
  logic [23:0] q0[$], q1[$];
  bit          expErr = 0;

  asym_pack_fifo_s1 #(.byte_order(0)) uDutMsb (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .flush_n(flush_n),
    .pop_req_n(pop_req_n), .data_in(data_in),
    .empty(emptyS[0]), .almost_empty(almostEmptyS[0]), .half_full(halfFullS[0]),
    .almost_full(almostFullS[0]), .ram_full(ramFullS[0]), .full(fullS[0]),
    .part_wd(partWdS[0]), .error(errorS[0]), .data_out(dataOutS[0])
  );

  asym_pack_fifo_s1 #(.byte_order(1)) uDutLsb (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .flush_n(flush_n),
    .pop_req_n(pop_req_n), .data_in(data_in),
    .empty(emptyS[1]), .almost_empty(almostEmptyS[1]), .half_full(halfFullS[1]),
    .almost_full(almostFullS[1]), .ram_full(ramFullS[1]), .full(fullS[1]),
    .part_wd(partWdS[1]), .error(errorS[1]), .data_out(dataOutS[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    if (obs !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [23:0] packStage(input int order);
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < stage.size(); i++) begin
      if (order == 0) w |= 24'(stage[i]) << (8 * (K - 1 - i));
      else            w |= 24'(stage[i]) << (8 * i);
    end
    return w;
  endfunction

  task automatic modelReset();
    pend.delete();
    q0.delete();
    q1.delete();
    expErr = 0;
  endtask

  // One clock of FIFO behaviour expressed as queue operations.
  task automatic modelStep(input bit push, input bit flush, input bit pop, input logic [7:0] d);
    int  cnt;
    bit  popOk, wrOk, needWrite, fault;
    cnt   = q0.size();
    popOk = pop && cnt > 0;
    wrOk  = (cnt < DEPTH) || popOk;
    fault = 0;
    stage = pend;
    if (push) stage.push_back(d);
    needWrite = (stage.size() == K) || (flush && stage.size() > 0);
    if (needWrite && !wrOk) fault = 1;
    if (pop && cnt == 0) fault = 1;
    if (popOk) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    if (needWrite && wrOk) begin
      q0.push_back(packStage(0));
      q1.push_back(packStage(1));
      pend.delete();
    end else if (!needWrite) begin
      pend = stage;
    end
`ifdef ASYM_PACK_FIFO_STICKY_ERR_EN
    expErr = expErr | fault;
`else
    expErr = fault;
`endif
  endtask

  task automatic checkAll();
    int cnt;
    logic [23:0] head;
    cnt = q0.size();
    for (int i = 0; i < 2; i++) begin
      head = '0;
      if (cnt > 0) head = (i == 0) ? q0[0] : q1[0];
      checkOutput($sformatf("empty%0d", i), emptyS[i], cnt == 0);
      checkOutput($sformatf("almost_empty%0d", i), almostEmptyS[i], cnt <= 2);
      checkOutput($sformatf("half_full%0d", i), halfFullS[i], cnt >= (DEPTH + 1) / 2);
      checkOutput($sformatf("almost_full%0d", i), almostFullS[i], cnt >= DEPTH - 2);
      checkOutput($sformatf("ram_full%0d", i), ramFullS[i], cnt == DEPTH);
      checkOutput($sformatf("full%0d", i), fullS[i], cnt == DEPTH && pend.size() == K - 1);
      checkOutput($sformatf("part_wd%0d", i), partWdS[i], pend.size() > 0);
      checkOutput($sformatf("error%0d", i), errorS[i], expErr);
      checkOutput($sformatf("data_out%0d", i), dataOutS[i], head);
    end
  endtask

  task automatic checkResetValues(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_flags"},
                  {emptyS[i], almostEmptyS[i], halfFullS[i], almostFullS[i],
                   ramFullS[i], fullS[i], partWdS[i], errorS[i]}, 8'b1100_0000);
      checkOutput({tag, "_data_out"}, dataOutS[i], 24'h0);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic applyStimulus(input bit push, input bit flush, input bit pop, input logic [7:0] d);
    push_req_n = !push;
    flush_n    = !flush;
    pop_req_n  = !pop;
    data_in    = d;
    modelStep(push, flush, pop, d);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    int popPct;
    rst = 1'b1;
    push_req_n = 1'b1;
    flush_n = 1'b1;
    pop_req_n = 1'b1;
    data_in = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 8'h11 + 8'(i));
    checkOutput("first_word_msb", dataOutS[0], 24'h111213);
    checkOutput("first_word_lsb", dataOutS[1], 24'h131211);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("second_word_msb", dataOutS[0], 24'h141516);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("drained_empty", emptyS[0], 1'b1);

    applyStimulus(1, 0, 0, 8'hAA);
    applyStimulus(1, 0, 0, 8'hBB);
    applyStimulus(1, 0, 0, 8'hCC);
    checkOutput("lsb_first_word", dataOutS[1], 24'hCCBBAA);
    applyStimulus(0, 0, 1, 8'h00);

    applyStimulus(1, 0, 0, 8'h01);
    applyStimulus(1, 0, 0, 8'h02);
    checkOutput("partial_before_flush", partWdS[0], 1'b1);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("partial_after_flush", partWdS[0], 1'b0);
    checkOutput("flushed_word_msb", dataOutS[0], 24'h010200);
    checkOutput("flushed_word_lsb", dataOutS[1], 24'h000201);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'h00);

    for (int i = 0; i < DEPTH * K + 2; i++) applyStimulus(1, 0, 0, 8'(8'h30 + i));
    checkOutput("fill_full", fullS[0], 1'b1);
    applyStimulus(1, 0, 0, 8'hEE);
    checkOutput("overflow_error", errorS[0], 1'b1);
    checkOutput("overflow_ram_full", ramFullS[0], 1'b1);
    applyStimulus(1, 1, 0, 8'hEF);
    applyStimulus(1, 0, 1, 8'hEE);
    checkOutput("push_with_pop_full", fullS[0], 1'b0);
    checkOutput("push_with_pop_ram_full", ramFullS[0], 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, 8'h00);
    checkOutput("underflow_error", errorS[0], 1'b1);
    applyStimulus(0, 0, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);

    for (int i = 0; i < 5 * K + 1; i++) applyStimulus(1, 0, 0, 8'(8'h50 + i));
    rst = 1'b1;
    #1;
    checkResetValues("async_reset");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 8'h77);

    for (int iter = 0; iter < 1500; iter++) begin
      popPct = ((iter / 250) % 2 == 1) ? 60 : 25;
      if (iter % 400 == 399) begin
        rst = 1'b1;
        modelReset();
        @(negedge clk);
        checkResetValues("random_reset");
        rst = 1'b0;
      end
      applyStimulus($urandom_range(99) < 60, $urandom_range(99) < 10,
                    $urandom_range(99) < popPct, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
